// File: rtl/mod_mult_responder.sv
// -----------------------------------------------------------------------------
// mod_mult_responder
//
// Pipelined integer multiplier serving operand-pair requests from the
// modular-reduction pipes. A request {B, A} enters on a valid/ready stream.
// The full 2*DAT_BITS product leaves on a valid/ready stream, in request
// order, and the request tag travels alongside it.
//
// How the product is built:
//   - Stage 1 multiplies A by the lowest CHUNK_BITS slice of B.
//   - Each later stage adds A times the next slice, shifted into place.
//   - There are NSTAGE stages, and NSTAGE is also the latency.
//   - Stage NSTAGE is the output register.
//
// Backpressure is a single global enable: the whole pipeline either advances
// or holds, including empty stages. Bubbles are not collapsed.
//
// Optional feature (macro MOD_MULT_RESP_CNT_EN):
//   - Defined: o_cnt counts completed responses (o_val & i_rdy) and wraps
//     modulo 2^32.
//   - Undefined: o_cnt is tied to zero and no counter logic is generated.
//
// Ports:
//   i_clk, i_rst   clock; synchronous active-high reset
//   i_dat          request operands: A = i_dat[0 +: DAT_BITS],
//                  B = i_dat[DAT_BITS +: DAT_BITS]
//   i_val, i_ctl   request valid and tag
//   o_rdy          request ready (combinational global enable)
//   o_dat          product A*B
//   o_val, o_ctl   response valid and tag
//   i_rdy          downstream ready
//   o_cnt          completed-response count (zero when the feature is off)
// -----------------------------------------------------------------------------
module mod_mult_responder #(
    parameter int DAT_BITS   = 256,
    parameter int CTL_BITS   = 8,
    parameter int CHUNK_BITS = 64
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [2*DAT_BITS-1:0] i_dat,
    input  logic                  i_val,
    input  logic [CTL_BITS-1:0]   i_ctl,
    output logic                  o_rdy,
    output logic [2*DAT_BITS-1:0] o_dat,
    output logic                  o_val,
    output logic [CTL_BITS-1:0]   o_ctl,
    input  logic                  i_rdy,
    output logic [31:0]           o_cnt
);

    localparam int NSTAGE = (DAT_BITS + CHUNK_BITS - 1) / CHUNK_BITS;
    localparam int PW     = 2 * DAT_BITS;
    localparam int BXW    = NSTAGE * CHUNK_BITS;
    // Operands are needed only by stages 2..NSTAGE. The output stage keeps
    // just the accumulator and the tag.
    localparam int NOPS   = (NSTAGE > 1) ? (NSTAGE - 1) : 1;

    // A * B[k-th chunk], shifted into position. B is zero-extended so that a
    // short final chunk reads zeros above DAT_BITS.
    function automatic logic [PW-1:0] chunk_term(input logic [DAT_BITS-1:0] a,
                                                 input logic [DAT_BITS-1:0] b,
                                                 input int                  k);
        logic [BXW-1:0] b_ext;
        logic [PW-1:0]  prod;
        b_ext                 = '0;
        b_ext[DAT_BITS-1:0]   = b;
        prod                  = PW'(a) * PW'(b_ext[k*CHUNK_BITS +: CHUNK_BITS]);
        chunk_term            = prod << (k * CHUNK_BITS);
    endfunction

    logic                en_s;
    logic                accept_s;
    logic [DAT_BITS-1:0] a_in_s;
    logic [DAT_BITS-1:0] b_in_s;

    logic [NSTAGE-1:0]   val_q, val_d;
    logic [DAT_BITS-1:0] a_q   [NOPS];
    logic [DAT_BITS-1:0] a_d   [NOPS];
    logic [DAT_BITS-1:0] b_q   [NOPS];
    logic [DAT_BITS-1:0] b_d   [NOPS];
    logic [CTL_BITS-1:0] ctl_q [NSTAGE];
    logic [CTL_BITS-1:0] ctl_d [NSTAGE];
    logic [PW-1:0]       acc_q [NSTAGE];
    logic [PW-1:0]       acc_d [NSTAGE];

    // Global enable: advance unless a held response is waiting on downstream.
    always_comb begin
        en_s     = ~val_q[NSTAGE-1] | i_rdy;
        accept_s = i_val & en_s;
        a_in_s   = i_dat[0 +: DAT_BITS];
        b_in_s   = i_dat[DAT_BITS +: DAT_BITS];
    end

    // Next state for every stage. Everything holds when the enable is low.
    always_comb begin
        val_d = val_q;
        a_d   = a_q;
        b_d   = b_q;
        ctl_d = ctl_q;
        acc_d = acc_q;
        if (en_s) begin
            // Stage 1 loads on accept. Otherwise it becomes a bubble.
            val_d[0] = accept_s;
            if (accept_s) begin
                a_d[0]   = a_in_s;
                b_d[0]   = b_in_s;
                ctl_d[0] = i_ctl;
                acc_d[0] = chunk_term(a_in_s, b_in_s, 0);
            end else begin
                ctl_d[0] = ctl_q[0];
            end
            for (int k = 1; k < NOPS; k++) begin
                a_d[k] = a_q[k-1];
                b_d[k] = b_q[k-1];
            end
            for (int k = 1; k < NSTAGE; k++) begin
                val_d[k] = val_q[k-1];
                ctl_d[k] = ctl_q[k-1];
                acc_d[k] = acc_q[k-1] + chunk_term(a_q[k-1], b_q[k-1], k);
            end
        end else begin
            val_d = val_q;
        end
    end

    // Stage valid bits: the only pipeline state that needs a reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            val_q <= '0;
        end else begin
            val_q <= val_d;
        end
    end

    // Datapath registers; contents are qualified by the valid bits.
    always_ff @(posedge i_clk) begin
        a_q   <= a_d;
        b_q   <= b_d;
        ctl_q <= ctl_d;
        acc_q <= acc_d;
    end

    assign o_rdy = en_s;
    assign o_val = val_q[NSTAGE-1];
    assign o_dat = acc_q[NSTAGE-1];
    assign o_ctl = ctl_q[NSTAGE-1];

`ifdef MOD_MULT_RESP_CNT_EN
    logic [31:0] cnt_q, cnt_d;

    // Completed-response count; wraps naturally at 2^32.
    always_comb begin
        if (val_q[NSTAGE-1] & i_rdy) begin
            cnt_d = cnt_q + 32'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_cnt = cnt_q;
`else
    assign o_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_mod_mult_responder.sv
module tb_mod_mult_responder;

    localparam int DW = 16;
    localparam int CW = 8;
`ifdef MOD_MULT_RESP_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          i_rst = 1'b0;
    logic [2*DW-1:0] i_dat = '0;
    logic          i_val = 1'b0;
    logic [CW-1:0] i_ctl = '0;
    logic          o_rdy;
    logic [2*DW-1:0] o_dat;
    logic          o_val;
    logic [CW-1:0] o_ctl;
    logic          i_rdy = 1'b0;
    logic [31:0]   o_cnt;

    mod_mult_responder #(.DAT_BITS(DW), .CTL_BITS(CW), .CHUNK_BITS(4)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_dat(i_dat), .i_val(i_val), .i_ctl(i_ctl),
        .o_rdy(o_rdy), .o_dat(o_dat), .o_val(o_val), .o_ctl(o_ctl),
        .i_rdy(i_rdy), .o_cnt(o_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0]   ctl;
        logic [2*DW-1:0] prod;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Per-cycle samples, taken before the edge on which handshakes happen.
    logic          s_acc, s_got, s_val, s_rdy, s_have;
    logic [2*DW-1:0] s_dat;
    logic [CW-1:0] s_ctl;
    logic [31:0]   s_cnt;
    exp_t          s_exp;

    // Drive one cycle, sample outputs, update the in-order reference queue.
    task automatic cycle(input logic rst, input logic v, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic [CW-1:0] c, input logic r);
        @(negedge clk);
        i_rst = rst; i_val = v; i_dat = {b, a}; i_ctl = c; i_rdy = r;
        #1;
        s_val = o_val; s_rdy = o_rdy; s_dat = o_dat; s_ctl = o_ctl; s_cnt = o_cnt;
        s_acc = v & o_rdy & ~rst;
        s_got = o_val & r & ~rst;
        s_have = 1'b0;
        if (s_got && q.size() != 0) begin
            s_exp  = q.pop_front();
            s_have = 1'b1;
        end
        if (s_acc) q.push_back({c, 32'(a) * 32'(b)});
        if (rst) q.delete();
        @(posedge clk);
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b0, 16'd0, 16'd0, 8'd0, 1'b1);
        cycle(1'b1, 1'b0, 16'd0, 16'd0, 8'd0, 1'b1);
        cycle(1'b0, 1'b0, 16'd0, 16'd0, 8'd0, 1'b1);
        n_cmp++; if (s_val !== 1'b0) begin n_bad++; $display("FAIL reset_oval got %b want 0", s_val); end
        n_cmp++; if (s_rdy !== 1'b1) begin n_bad++; $display("FAIL reset_ordy got %b want 1", s_rdy); end
        n_cmp++; if (s_cnt !== 32'd0) begin n_bad++; $display("FAIL reset_ocnt got %h want 0", s_cnt); end
    endtask

    task automatic test_all_ones();
        int first = 0;
        cycle(1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 8'h5A, 1'b1);
        n_cmp++; if (s_acc !== 1'b1) begin n_bad++; $display("FAIL ones_accept got %b want 1", s_acc); end
        for (int n = 1; n <= 8; n++) begin
            cycle(1'b0, 1'b0, 16'd0, 16'd0, 8'd0, 1'b1);
            if (s_got) begin
                if (first == 0) first = n;
                n_cmp++;
                if (!s_have || s_dat !== 32'hFFFE0001 || s_ctl !== 8'h5A) begin
                    n_bad++; $display("FAIL ones_resp got %h/%h want fffe0001/5a", s_dat, s_ctl);
                end
            end
        end
        n_cmp++; if (first != 4) begin n_bad++; $display("FAIL ones_latency got %0d want 4", first); end
    endtask

    task automatic test_streaming();
        int got_n = 0;
        for (int k = 0; k < 32; k++) begin
            cycle(1'b0, 1'b1, 16'(k), 16'(k + 3), 8'(k), 1'b1);
            n_cmp++; if (s_rdy !== 1'b1) begin n_bad++; $display("FAIL stream_ordy k=%0d got %b want 1", k, s_rdy); end
            if (s_got) begin
                got_n++; n_cmp++;
                if (!s_have || s_dat !== s_exp.prod || s_ctl !== s_exp.ctl) begin
                    n_bad++; $display("FAIL stream_resp got %h/%h want %h/%h", s_dat, s_ctl, s_exp.prod, s_exp.ctl);
                end
            end
        end
        for (int i = 0; i < 20 && q.size() != 0; i++) begin
            cycle(1'b0, 1'b0, 16'd0, 16'd0, 8'd0, 1'b1);
            n_cmp++; if (s_val !== 1'b1) begin n_bad++; $display("FAIL stream_gap got o_val %b want 1", s_val); end
            if (s_got) begin
                got_n++; n_cmp++;
                if (!s_have || s_dat !== s_exp.prod || s_ctl !== s_exp.ctl) begin
                    n_bad++; $display("FAIL stream_resp got %h/%h want %h/%h", s_dat, s_ctl, s_exp.prod, s_exp.ctl);
                end
            end
        end
        n_cmp++; if (got_n != 32) begin n_bad++; $display("FAIL stream_count got %0d want 32", got_n); end
    endtask

    task automatic test_backpressure();
        int sent = 0, got_n = 0;
        logic r, pv, pr;
        logic [2*DW-1:0] pd;
        logic [CW-1:0] pc;
        logic [DW-1:0] a, b;
        pv = 1'b0; pr = 1'b1; pd = '0; pc = '0;
        a = 16'($urandom); b = 16'($urandom);
        for (int c = 0; c < 60 && (sent < 8 || q.size() != 0); c++) begin
            r = !(c >= 4 && c < 9);
            cycle(1'b0, sent < 8, a, b, 8'(8'h80 + sent), r);
            if (s_acc) begin sent++; a = 16'($urandom); b = 16'($urandom); end
            if (!r && s_val) begin
                n_cmp++; if (s_rdy !== 1'b0) begin n_bad++; $display("FAIL bp_ordy got %b want 0", s_rdy); end
            end
            if (pv && !pr) begin
                n_cmp++;
                if (s_val !== 1'b1 || s_dat !== pd || s_ctl !== pc) begin
                    n_bad++; $display("FAIL bp_hold got %b/%h/%h want 1/%h/%h", s_val, s_dat, s_ctl, pd, pc);
                end
            end
            if (s_got) begin
                got_n++; n_cmp++;
                if (!s_have || s_dat !== s_exp.prod || s_ctl !== s_exp.ctl) begin
                    n_bad++; $display("FAIL bp_resp got %h/%h want %h/%h", s_dat, s_ctl, s_exp.prod, s_exp.ctl);
                end
            end
            pv = s_val; pr = r; pd = s_dat; pc = s_ctl;
        end
        n_cmp++; if (got_n != 8) begin n_bad++; $display("FAIL bp_count got %0d want 8", got_n); end
    endtask

    task automatic test_edge_operands();
        logic [DW-1:0]   ea [3];
        logic [DW-1:0]   eb [3];
        logic [2*DW-1:0] ep [3];
        int got_n = 0;
        ea[0] = 16'h0000; eb[0] = 16'hFFFF; ep[0] = 32'h0;
        ea[1] = 16'h0001; eb[1] = 16'h8001; ep[1] = 32'h8001;
        ea[2] = 16'h8000; eb[2] = 16'h8000; ep[2] = 32'h40000000;
        for (int c = 0; c < 20 && (c < 3 || q.size() != 0); c++) begin
            if (c < 3) cycle(1'b0, 1'b1, ea[c], eb[c], 8'(8'hE0 + c), 1'b1);
            else       cycle(1'b0, 1'b0, 16'd0, 16'd0, 8'd0, 1'b1);
            if (s_got) begin
                n_cmp++;
                if (got_n > 2 || !s_have || s_dat !== ep[got_n] || s_ctl !== 8'(8'hE0 + got_n)) begin
                    n_bad++; $display("FAIL edge_resp idx=%0d got %h/%h want %h", got_n, s_dat, s_ctl, ep[got_n % 3]);
                end
                got_n++;
            end
        end
        n_cmp++; if (got_n != 3) begin n_bad++; $display("FAIL edge_count got %0d want 3", got_n); end
    endtask

    task automatic test_reset_mid();
        int first = 0, got_n = 0;
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, 16'(k + 10), 16'(k + 20), 8'(k), 1'b1);
        cycle(1'b1, 1'b0, 16'd0, 16'd0, 8'd0, 1'b1);
        cycle(1'b0, 1'b1, 16'd3, 16'd7, 8'h33, 1'b1);
        n_cmp++; if (s_val !== 1'b0) begin n_bad++; $display("FAIL rstmid_oval got %b want 0", s_val); end
        n_cmp++; if (s_rdy !== 1'b1) begin n_bad++; $display("FAIL rstmid_ordy got %b want 1", s_rdy); end
        for (int n = 1; n <= 8; n++) begin
            cycle(1'b0, 1'b0, 16'd0, 16'd0, 8'd0, 1'b1);
            if (s_got) begin
                got_n++;
                if (first == 0) first = n;
                n_cmp++;
                if (s_dat !== 32'd21 || s_ctl !== 8'h33) begin
                    n_bad++; $display("FAIL rstmid_resp got %h/%h want 15/33", s_dat, s_ctl);
                end
            end
        end
        n_cmp++; if (got_n != 1 || first != 4) begin n_bad++; $display("FAIL rstmid_count got %0d at %0d want 1 at 4", got_n, first); end
    endtask

    task automatic test_counter();
        int sent = 0, got_n = 0;
        logic [31:0] cnt_exp = 32'd0;
        logic r;
        cycle(1'b1, 1'b0, 16'd0, 16'd0, 8'd0, 1'b1);
        for (int c = 0; c < 40 && got_n < 10; c++) begin
            r = !(c == 6 || c == 10);
            cycle(1'b0, sent < 10, 16'(c * 7), 16'(c + 1), 8'(c), r);
            if (s_acc) sent++;
            n_cmp++;
            if (s_cnt !== (CNT_ON ? cnt_exp : 32'd0)) begin
                n_bad++; $display("FAIL cnt_track got %h want %h", s_cnt, CNT_ON ? cnt_exp : 32'd0);
            end
            if (s_got) begin
                got_n++; cnt_exp++; n_cmp++;
                if (!s_have || s_dat !== s_exp.prod || s_ctl !== s_exp.ctl) begin
                    n_bad++; $display("FAIL cnt_resp got %h/%h want %h/%h", s_dat, s_ctl, s_exp.prod, s_exp.ctl);
                end
            end
        end
        cycle(1'b0, 1'b0, 16'd0, 16'd0, 8'd0, 1'b1);
        n_cmp++;
        if (s_cnt !== (CNT_ON ? 32'd10 : 32'd0)) begin
            n_bad++; $display("FAIL cnt_final got %h want %h", s_cnt, CNT_ON ? 32'd10 : 32'd0);
        end
`ifdef MOD_MULT_RESP_CNT_EN
        @(negedge clk);
        force dut.cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.cnt_q;
        @(posedge clk);
        cycle(1'b0, 1'b1, 16'd5, 16'd6, 8'h66, 1'b1);
        n_cmp++; if (s_cnt !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL cnt_preload got %h want ffffffff", s_cnt); end
        got_n = 0;
        for (int i = 0; i < 10 && got_n == 0; i++) begin
            cycle(1'b0, 1'b0, 16'd0, 16'd0, 8'd0, 1'b1);
            if (s_got) got_n++;
        end
        cycle(1'b0, 1'b0, 16'd0, 16'd0, 8'd0, 1'b1);
        n_cmp++; if (got_n != 1 || s_cnt !== 32'd0) begin n_bad++; $display("FAIL cnt_wrap got %h want 0", s_cnt); end
`endif
    endtask

    task automatic test_random();
        logic v, r;
        for (int c = 0; c < 300; c++) begin
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 3) != 0);
            cycle(1'b0, v, 16'($urandom), 16'($urandom), 8'($urandom), r);
            if (s_got) begin
                n_cmp++;
                if (!s_have || s_dat !== s_exp.prod || s_ctl !== s_exp.ctl) begin
                    n_bad++; $display("FAIL rand_resp got %h/%h want %h/%h", s_dat, s_ctl, s_exp.prod, s_exp.ctl);
                end
            end
        end
        for (int i = 0; i < 20 && q.size() != 0; i++) begin
            cycle(1'b0, 1'b0, 16'd0, 16'd0, 8'd0, 1'b1);
            if (s_got) begin
                n_cmp++;
                if (!s_have || s_dat !== s_exp.prod || s_ctl !== s_exp.ctl) begin
                    n_bad++; $display("FAIL rand_resp got %h/%h want %h/%h", s_dat, s_ctl, s_exp.prod, s_exp.ctl);
                end
            end
        end
        n_cmp++; if (q.size() != 0) begin n_bad++; $display("FAIL rand_drain got %0d pending want 0", q.size()); end
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_streaming();
        test_backpressure();
        test_edge_operands();
        test_reset_mid();
        test_counter();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mod_mult_responder.md
Name: mod_mult_responder

Overview:
- Pipelined integer multiplier that serves operand-pair requests from the modular-reduction pipes. It is the responder end of their multiplier request/response stream.
- Accepts {B, A} on a valid/ready input stream and returns the full 2*DAT_BITS product on a valid/ready output stream. CTL travels alongside each product.
- Builds the product by chunked partial-product accumulation over NSTAGE register stages, with a global-stall backpressure scheme.

Parameters:
- DAT_BITS, 256, operand width; the product is 2*DAT_BITS.
- CTL_BITS, 8, width of the tag carried with each request.
- CHUNK_BITS, 64, width of the B slice multiplied per stage.
- NSTAGE (localparam), ceil(DAT_BITS/CHUNK_BITS), number of pipeline stages and the latency.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous, active-high reset
- i_dat  in  2*DAT_BITS  request operands: A = i_dat[0 +: DAT_BITS], B = i_dat[DAT_BITS +: DAT_BITS]
- i_val  in  1  request valid
- i_ctl  in  CTL_BITS  request tag
- o_rdy  out  1  request ready
- o_dat  out  2*DAT_BITS  product A*B
- o_val  out  1  response valid
- o_ctl  out  CTL_BITS  tag of the request that produced o_dat
- i_rdy  in  1  downstream ready
- o_cnt  out  32  completed-response count (see Optional Feature)

Behaviour:
- Reset (clock i_clk, reset i_rst, synchronous, active-high):
  - o_val=0; all stage valid bits=0; o_cnt=0.
  - o_dat and o_ctl are don't-care (no reset needed).
- Global enable: en = ~o_val | i_rdy. o_rdy = en, combinational.
- No bubble collapsing: when en=0 the entire pipeline holds, including empty stages.
- Accept: a request is taken when i_val & o_rdy.
  - Stage 1 captures A, B, ctl, val=1.
  - Stage 1 also captures acc = A * B[0 +: CHUNK_BITS].
- Stage k, for k=2..NSTAGE, when en:
  - Takes A, B, ctl and val from stage k-1.
  - acc_k = acc_{k-1} + ((A * B[(k-1)*CHUNK_BITS +: CHUNK_BITS]) << ((k-1)*CHUNK_BITS)).
- The last chunk is zero-extended when DAT_BITS is not a multiple of CHUNK_BITS.
- The accumulator is 2*DAT_BITS wide; it never overflows because A, B < 2^DAT_BITS.
- Stage NSTAGE is the output register: o_val, o_dat=acc, o_ctl.
- When en=1 and stage 1 is not being loaded, stage 1 val is cleared to 0, which inserts a bubble.
- Latency: with i_rdy held high, a request accepted at edge t gives o_val=1 after edge t+NSTAGE-1. That is NSTAGE register stages. Throughput is 1 per cycle.
- Hold rule: while o_val=1 and i_rdy=0:
  - o_dat and o_ctl stay stable.
  - o_rdy=0, and nothing advances.
- Simultaneous output consumption and input acceptance in the same cycle is legal; the pipeline shifts by one.
- Ordering: responses come out in request order. ctl is passed through unmodified, which lets requesters match responses to requests.
- i_val=0 with o_rdy=1: a bubble enters, and o_val later falls for one cycle accordingly.
- Reset mid-operation: all in-flight requests are discarded, no response is produced for them, and o_rdy=1 on the first cycle after reset.
- The values of A and B are not checked; any value, including 0 and all-ones, is legal.

Optional Feature:
- Macro: MOD_MULT_RESP_CNT_EN.
- Defined:
  - o_cnt increments by 1 on every cycle with o_val & i_rdy.
  - It wraps modulo 2^32 (0xFFFFFFFF -> 0).
  - It resets to 0.
- Undefined: o_cnt is tied to 0 and no counter logic is generated.

Test Plan:
- Use DAT_BITS=16, CHUNK_BITS=4 (NSTAGE=4) for all scenarios.
- Scenario 1, all-ones: i_dat={16'hFFFF,16'hFFFF}, ctl=8'h5A, i_rdy=1 -> o_dat=32'hFFFE0001, o_ctl=8'h5A. o_val is seen on the 4th edge after acceptance.
- Scenario 2, streaming: requests A=k, B=k+3 with ctl=k for k=0..31, one per cycle, i_rdy=1 -> 32 back-to-back responses in order, each o_dat=k*(k+3), and o_rdy stays 1 throughout.
- Scenario 3, backpressure:
  - Stimulus: stream 8 requests and drop i_rdy low for 5 cycles mid-stream.
  - Required: o_rdy=0 during the stall, and o_dat/o_ctl stay stable while o_val=1 & i_rdy=0.
  - Required: all 8 products are correct, none lost or duplicated.
- Scenario 4, edge operands: A=0,B=0xFFFF -> 0; A=1,B=0x8001 -> 0x8001; A=0x8000,B=0x8000 -> 0x40000000.
- Scenario 5, reset mid-operation:
  - Stimulus: 3 requests in flight, then assert i_rst for 1 cycle.
  - Required: o_val=0 after the reset edge, no responses for the flushed requests, and a new request A=3,B=7 returns 21 after 4 cycles.
- Scenario 6, counter with MOD_MULT_RESP_CNT_EN:
  - Stimulus: 10 responses consumed, with 2 of them stalled for one cycle.
  - Required: o_cnt=10.
  - Preloading via force at 0xFFFFFFFF and consuming one response gives 0.
  - With the macro undefined, o_cnt stays 0.
